// File: rtl/lsu_mem_port.sv
// Load/store memory port: a single outstanding request against an internal
// 64-bit word array, with a fixed response latency and sized, sign/zero
// extended loads. Stores commit on the accepting edge; loads capture their
// result on that same edge and hold it until the consumer takes it.
module lsu_mem_port #(
    parameter int          DEPTH     = 1024,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
    parameter int          LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [63:0] SPAN     = 64'(DEPTH) << 3;
    // BUSY counts down from LATENCY-2 so RESP starts LATENCY cycles after accept
    localparam logic [2:0]  CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Address low bits must be a multiple of the access size
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lane);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return lane[0];
            2'd2:    return |lane[1:0];
            2'd3:    return |lane;
            default: return 1'b1;
        endcase
    endfunction

    // Byte-enable mask for the access, positioned at its lane
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] lane);
        logic [7:0] base;
        case (size)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            2'd2:    base = 8'h0F;
            2'd3:    base = 8'hFF;
            default: base = 8'h00;
        endcase
        return base << lane;
    endfunction

    // Keep the low 8*2^size bits of a right-aligned value and extend them
    function automatic logic [63:0] extend_load(input logic [63:0] raw, input logic [1:0] size,
                                                input logic sgn);
        case (size)
            2'd0:    return sgn ? {{56{raw[7]}},  raw[7:0]}  : {56'd0, raw[7:0]};
            2'd1:    return sgn ? {{48{raw[15]}}, raw[15:0]} : {48'd0, raw[15:0]};
            2'd2:    return sgn ? {{32{raw[31]}}, raw[31:0]} : {32'd0, raw[31:0]};
            2'd3:    return raw;
            default: return 64'd0;
        endcase
    endfunction

    logic [63:0] mem_q [DEPTH];

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic          accept_s;
    logic [63:0]   offset_s;
    logic          in_range_s;
    logic [2:0]    lane_s;
    logic [AW-1:0] idx_s;
    logic          err_s;
    logic [7:0]    mask_s;
    logic [63:0]   wshift_s;
    logic [63:0]   rword_s;
    logic [63:0]   load_s;
    logic          wr_en_s;

    // Offset from BASE_ADDR avoids overflow of BASE_ADDR + span at the top of the address map
    assign accept_s   = req_valid & (state_q == IDLE);
    assign offset_s   = req_addr - BASE_ADDR;
    assign in_range_s = (req_addr >= BASE_ADDR) && (offset_s < SPAN);
    assign lane_s     = req_addr[2:0];
    assign idx_s      = offset_s[3 +: AW];
    assign err_s      = ~in_range_s | misaligned(req_size, lane_s);
    assign mask_s     = lane_mask(req_size, lane_s);
    assign wshift_s   = req_wdata << {lane_s, 3'b000};
    assign rword_s    = mem_q[idx_s];
    assign load_s     = extend_load(rword_s >> {lane_s, 3'b000}, req_size, req_signed);
    assign wr_en_s    = accept_s & req_wen & ~err_s & ~rst;

    // Next-state logic: capture the response on accept, wait out the latency, hand off
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    err_d   = err_s;
                    rdata_d = (req_wen | err_s) ? 64'd0 : load_s;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == 3'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Control and response registers; reset drops any pending response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Byte-masked store into the array; contents are intentionally not reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            if (wr_en_s && mask_s[b]) begin
                mem_q[idx_s][8*b +: 8] <= wshift_s[8*b +: 8];
            end
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: three instances (LATENCY 2, 1, 8) share the
// request fields; each has its own rst and req_valid.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic [2:0]  rst_v;
    logic [2:0]  req_valid_v;
    logic [2:0]  req_ready_v;
    logic [2:0]  resp_valid_v;
    logic [2:0]  resp_err_v;
    logic [63:0] resp_rdata_a [3];
    logic        req_wen;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_ready;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

    always #5 clk = ~clk;

    lsu_mem_port #(.DEPTH(1024), .BASE_ADDR(BASE), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst_v[0]), .req_valid(req_valid_v[0]), .req_ready(req_ready_v[0]),
        .req_wen(req_wen), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid_v[0]), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata_a[0]), .resp_err(resp_err_v[0]));

    lsu_mem_port #(.DEPTH(16), .BASE_ADDR(BASE), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst_v[1]), .req_valid(req_valid_v[1]), .req_ready(req_ready_v[1]),
        .req_wen(req_wen), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid_v[1]), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata_a[1]), .resp_err(resp_err_v[1]));

    lsu_mem_port #(.DEPTH(16), .BASE_ADDR(BASE), .LATENCY(8)) u_dut_l8 (
        .clk(clk), .rst(rst_v[2]), .req_valid(req_valid_v[2]), .req_ready(req_ready_v[2]),
        .req_wen(req_wen), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid_v[2]), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata_a[2]), .resp_err(resp_err_v[2]));

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete request/response with resp_ready held high; called #1 after an edge
    task automatic transact(input int d, input logic wen, input logic [1:0] size, input logic sgn,
                            input logic [63:0] addr, input logic [63:0] wdata,
                            output logic [63:0] rdata, output logic err,
                            output int lat, output int waited);
        req_wen = wen; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid_v[d] = 1'b1;
        waited = 0;
        while (req_ready_v[d] !== 1'b1 && waited < 50) begin
            @(posedge clk); #1; waited++;
        end
        @(posedge clk); #1;
        req_valid_v[d] = 1'b0;
        lat = 1;
        while (resp_valid_v[d] !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        rdata = resp_rdata_a[d];
        err   = resp_err_v[d];
        @(posedge clk); #1;
    endtask

    task automatic op(input string tag, input int d, input logic wen, input logic [1:0] size,
                      input logic sgn, input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [63:0] exp_rdata, input logic exp_err, input int exp_lat);
        logic [63:0] rd;
        logic        er;
        int          lat;
        int          waited;
        transact(d, wen, size, sgn, addr, wdata, rd, er, lat, waited);
        check64({tag, "_wait"}, 64'(waited), 64'd0);
        check64({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check64({tag, "_rdata"}, rd, exp_rdata);
        check64({tag, "_err"}, {63'd0, er}, {63'd0, exp_err});
    endtask

    // Store dword, reset after 'delay' further edges, then reload it
    task automatic reset_mid(input string tag, input int d, input logic [63:0] addr,
                             input logic [63:0] data, input int delay, input bit chk_seen,
                             input int exp_lat);
        logic seen;
        req_wen = 1'b1; req_size = 2'd3; req_signed = 1'b0; req_addr = addr; req_wdata = data;
        req_valid_v[d] = 1'b1;
        @(posedge clk); #1;
        req_valid_v[d] = 1'b0;
        seen = resp_valid_v[d];
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1; seen = seen | resp_valid_v[d];
        end
        rst_v[d] = 1'b1;
        #1;
        check64({tag, "_rst_ready"}, {63'd0, req_ready_v[d]}, 64'd1);
        check64({tag, "_rst_valid"}, {63'd0, resp_valid_v[d]}, 64'd0);
        check64({tag, "_rst_rdata"}, resp_rdata_a[d], 64'd0);
        @(posedge clk); #1;
        rst_v[d] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1; seen = seen | resp_valid_v[d];
        end
        if (chk_seen) check64({tag, "_no_resp"}, {63'd0, seen}, 64'd0);
        check64({tag, "_ready_after"}, {63'd0, req_ready_v[d]}, 64'd1);
        op({tag, "_reload"}, d, 1'b0, 2'd3, 1'b0, addr, 64'd0, data, 1'b0, exp_lat);
    endtask

    initial begin
        logic [63:0] held;
        int          lat;

        rst_v = 3'b111; req_valid_v = 3'b000; resp_ready = 1'b1;
        req_wen = 1'b0; req_size = 2'd0; req_signed = 1'b0; req_addr = 64'd0; req_wdata = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        check64("reset_ready", {61'd0, req_ready_v}, 64'd7);
        check64("reset_valid", {61'd0, resp_valid_v}, 64'd0);
        check64("reset_err", {61'd0, resp_err_v}, 64'd0);
        check64("reset_rdata", resp_rdata_a[0], 64'd0);
        rst_v = 3'b000;

        // Basic store/load and sub-word behaviour on the LATENCY=2 instance
        op("st_dw", 0, 1'b1, 2'd3, 1'b0, BASE, 64'h1122334455667788, 64'd0, 1'b0, 2);
        op("ld_dw", 0, 1'b0, 2'd3, 1'b0, BASE, 64'd0, 64'h1122334455667788, 1'b0, 2);
        op("st_b", 0, 1'b1, 2'd0, 1'b0, BASE + 64'd3, 64'h00000000000000AB, 64'd0, 1'b0, 2);
        op("ld_dw2", 0, 1'b0, 2'd3, 1'b0, BASE, 64'd0, 64'h11223344AB667788, 1'b0, 2);
        op("ld_bs", 0, 1'b0, 2'd0, 1'b1, BASE + 64'd3, 64'd0, 64'hFFFFFFFFFFFFFFAB, 1'b0, 2);
        op("ld_bu", 0, 1'b0, 2'd0, 1'b0, BASE + 64'd3, 64'd0, 64'h00000000000000AB, 1'b0, 2);
        op("ld_hs", 0, 1'b0, 2'd1, 1'b1, BASE + 64'd6, 64'd0, 64'h0000000000001122, 1'b0, 2);
        op("ld_ws", 0, 1'b0, 2'd2, 1'b1, BASE + 64'd0, 64'd0, 64'hFFFFFFFFAB667788, 1'b0, 2);
        op("st_w_mis", 0, 1'b1, 2'd2, 1'b0, BASE + 64'd2, 64'h00000000DEADBEEF, 64'd0, 1'b1, 2);
        op("ld_mis_chk", 0, 1'b0, 2'd3, 1'b0, BASE, 64'd0, 64'h11223344AB667788, 1'b0, 2);

        // Range boundaries: last valid word, just below base, one past the end
        op("st_last", 0, 1'b1, 2'd3, 1'b0, BASE + 64'h1FF8, 64'hCAFEF00D12345678, 64'd0, 1'b0, 2);
        op("ld_low", 0, 1'b0, 2'd3, 1'b0, 64'h000000007FFFFFF8, 64'd0, 64'd0, 1'b1, 2);
        op("ld_high", 0, 1'b0, 2'd3, 1'b0, BASE + 64'h2000, 64'd0, 64'd0, 1'b1, 2);
        op("st_low", 0, 1'b1, 2'd3, 1'b0, 64'h000000007FFFFFF8, 64'h5555555555555555, 64'd0, 1'b1, 2);
        op("st_high", 0, 1'b1, 2'd3, 1'b0, BASE + 64'h2000, 64'h6666666666666666, 64'd0, 1'b1, 2);
        op("ld_last_chk", 0, 1'b0, 2'd3, 1'b0, BASE + 64'h1FF8, 64'd0, 64'hCAFEF00D12345678, 1'b0, 2);
        op("ld_w0_chk", 0, 1'b0, 2'd3, 1'b0, BASE, 64'd0, 64'h11223344AB667788, 1'b0, 2);

        // Backpressure: response held 5 cycles, second request waits past the consume edge
        resp_ready = 1'b0;
        req_wen = 1'b0; req_size = 2'd3; req_signed = 1'b0; req_addr = BASE; req_wdata = 64'd0;
        req_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        check64("bp_accepted", {63'd0, req_ready_v[0]}, 64'd0);
        req_addr = BASE + 64'h1FF8;
        lat = 1;
        while (resp_valid_v[0] !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check64("bp_lat", 64'(lat), 64'd2);
        held = resp_rdata_a[0];
        check64("bp_rdata", held, 64'h11223344AB667788);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check64("bp_hold_valid", {63'd0, resp_valid_v[0]}, 64'd1);
            check64("bp_hold_rdata", resp_rdata_a[0], held);
            check64("bp_hold_ready", {63'd0, req_ready_v[0]}, 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check64("bp_consumed", {63'd0, resp_valid_v[0]}, 64'd0);
        check64("bp_not_accepted", {63'd0, req_ready_v[0]}, 64'd1);
        @(posedge clk); #1;
        check64("bp_second_accept", {63'd0, req_ready_v[0]}, 64'd0);
        req_valid_v[0] = 1'b0;
        lat = 1;
        while (resp_valid_v[0] !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check64("bp2_lat", 64'(lat), 64'd2);
        check64("bp2_rdata", resp_rdata_a[0], 64'hCAFEF00D12345678);
        @(posedge clk); #1;

        // Reset during an outstanding store on each latency variant
        reset_mid("rm_l2", 0, BASE + 64'h40, 64'h0123456789ABCDEF, 0, 1'b1, 2);
        reset_mid("rm_l1", 1, BASE + 64'h40, 64'hA5A5A5A55A5A5A5A, 0, 1'b0, 1);
        reset_mid("rm_l8", 2, BASE + 64'h78, 64'hFEDCBA9876543210, 3, 1'b1, 8);
        op("l8_ld_b", 2, 1'b0, 2'd0, 1'b1, BASE + 64'h7F, 64'd0, 64'hFFFFFFFFFFFFFFFE, 1'b0, 8);
        op("l1_ld_h", 1, 1'b0, 2'd1, 1'b0, BASE + 64'h42, 64'd0, 64'h0000000000005A5A, 1'b0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
